instr_seq: RTL and testbench
============================

INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high; has priority over every other input.
REQ-004 dbus  input  8  data bus; carries the instruction byte from RAM during fetch.
REQ-005 ir_ld  input  1  load IR from dbus on this edge; the downstream control generator drives it.
REQ-006 sm_en  input  1  enables the fetch/execute toggle; low freezes sm.
REQ-007 cf_en  input  1  carry-flag write enable.
REQ-008 zf_en  input  1  zero-flag write enable.
REQ-009 alu_c  input  1  ALU carry-out for the current cycle.
REQ-010 alu_z  input  1  ALU zero result for the current cycle.
REQ-011 ir  output  8  instruction register contents.
REQ-012 sm  output  1  cycle phase: 0 = fetch, 1 = execute.
REQ-013 mova movb movc add sub and1 not1 rsr rsl jmp jz jc in1 out1 nop halt  output  1 each  one-hot decode of ir.
REQ-014 c  output  1  registered carry flag.
REQ-015 z  output  1  registered zero flag.
REQ-016 icnt  output  8  count of instructions fetched.

Function
REQ-017 IR SHALL load dbus on a clock edge where ir_ld=1, and SHALL hold its value otherwise.
REQ-018 sm SHALL invert on every edge where sm_en=1, and SHALL hold on every edge where sm_en=0.
REQ-019 Decode SHALL be combinational from ir only and SHALL NOT be gated by sm.
REQ-020 Decode SHALL use opcode = ir[7:4] with the following map:
- 0000 nop
- 0001 halt
- 0010 in1
- 0100 out1
- 0101 not1
- 0110 sub
- 1001 add
- 1010 rsr
- 1011 and1
- 1100 rsl
REQ-021 Opcode 0011 SHALL be the jump group, selected by ir[1:0]:
- 00 jmp
- 01 jz
- 10 jc
- 11 nop
REQ-022 Opcode 1111 SHALL be the MOV group, resolved in this order:
- ir[3:2]=11 → movb (this has priority when ir[3:0]=1111)
- otherwise ir[1:0]=11 → movc
- otherwise mova
REQ-023 Unused opcodes 0111, 1000, 1101 and 1110 SHALL decode as nop.
REQ-024 Exactly one decode output SHALL be high at all times.
REQ-025 c SHALL take alu_c on an edge where cf_en=1 and sm=1, and SHALL hold otherwise.
REQ-026 z SHALL take alu_z on an edge where zf_en=1 and sm=1, and SHALL hold otherwise.
REQ-027 Flags SHALL never update during fetch (sm=0), even when cf_en or zf_en is asserted.
REQ-028 icnt SHALL increment by 1 on every edge where ir_ld=1, wrapping from 255 to 0 with no status flag.
REQ-029 Halt handling:
- Downstream drives sm_en = ~halt.
- Once a halt opcode is latched, sm SHALL stay at 1.
- IR, flags and icnt SHALL hold for as long as ir_ld and the flag enables stay low.
REQ-030 When ir_ld=1 and sm_en=1 on the same edge, the IR load and the sm toggle SHALL both take effect on that edge.
REQ-031 Latency: decode outputs SHALL be valid in the same cycle that IR changes (one edge after ir_ld).

Reset
REQ-032 When rst=1 on an edge, the block SHALL set ir=8'h00, sm=0, c=0, z=0 and icnt=8'h00.
REQ-033 After reset, decode SHALL show nop=1 and every other decode output 0.
REQ-034 Reset asserted mid-execute or while halted SHALL restore the REQ-032 state on the next edge and SHALL override ir_ld, sm_en, cf_en and zf_en.

Verification
REQ-035 Fetch: rst then release, dbus=8'h94, ir_ld=1, sm_en=1 for one edge → ir=8'h94, add=1, sm=1, icnt=1.
REQ-036 Flag gating: ir=8'h94, sm=0, zf_en=1, alu_z=1 for one edge → z stays 0; next edge with sm=1 → z=1.
REQ-037 MOV priority: ir=8'hFF → movb=1 and movc=0; ir=8'hF3 → movc=1; ir=8'hF4 → mova=1.
REQ-038 Halt: fetch dbus=8'h10 → halt=1 and sm=1. Hold sm_en=0 for 10 cycles → sm stays 1 and icnt is unchanged. Assert rst → sm=0, ir=0, nop=1.
REQ-039 Wrap and decode sweep:
- 256 fetches → icnt returns to 0.
- Sweep ir over 0x00–0xFF → exactly one decode output high for every value.

Source files
------------

// File: rtl/instr_seq_if.sv
// Instruction sequencer bus: control/ALU status in from the control generator,
// IR, phase, one-hot decode, flags and fetch count out.
interface instr_seq_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dbus;
    logic              ir_ld;
    logic              sm_en;
    logic              cf_en;
    logic              zf_en;
    logic              alu_c;
    logic              alu_z;

    logic [DATA_W-1:0] ir;
    logic              sm;
    logic              mova, movb, movc, add, sub, and1, not1, rsr;
    logic              rsl, jmp, jz, jc, in1, out1, nop, halt;
    logic              c;
    logic              z;
    logic [DATA_W-1:0] icnt;

    modport master (
        output dbus, ir_ld, sm_en, cf_en, zf_en, alu_c, alu_z,
        input  ir, sm, mova, movb, movc, add, sub, and1, not1, rsr,
        input  rsl, jmp, jz, jc, in1, out1, nop, halt, c, z, icnt
    );

    modport slave (
        input  dbus, ir_ld, sm_en, cf_en, zf_en, alu_c, alu_z,
        output ir, sm, mova, movb, movc, add, sub, and1, not1, rsr,
        output rsl, jmp, jz, jc, in1, out1, nop, halt, c, z, icnt
    );
endinterface

// File: rtl/instr_seq.sv
// Instruction sequencer: IR, fetch/execute phase toggle, one-hot opcode decode,
// carry/zero flags written only in execute, and a wrapping fetch counter.
module instr_seq (
    input  logic        clk,
    input  logic        rst,
    instr_seq_if.slave  bus
);

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    typedef struct packed {
        logic mova, movb, movc, add, sub, and1, not1, rsr;
        logic rsl, jmp, jz, jc, in1, out1, nop, halt;
    } dec_t;

    phase_t     state;
    phase_t     state_nxt;
    logic       exec_phase;
    logic [7:0] ir_q;
    logic       c_q;
    logic       z_q;
    logic [7:0] icnt_q;
    dec_t       dec;

    // Phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PH_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt is realised downstream by dropping sm_en, which simply freezes the phase
    always_comb begin
        state_nxt = state;
        if (bus.sm_en) begin
            state_nxt = (state == PH_FETCH) ? PH_EXEC : PH_FETCH;
        end
    end

    always_comb begin
        exec_phase = 1'b0;
        if (state == PH_EXEC) begin
            exec_phase = 1'b1;
        end
    end

    // IR, flags and fetch counter; flags only move in the execute phase
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q   <= 8'h00;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            icnt_q <= 8'h00;
        end else begin
            if (bus.ir_ld) begin
                ir_q   <= bus.dbus;
                icnt_q <= icnt_q + 8'd1;
            end
            if (bus.cf_en && exec_phase) begin
                c_q <= bus.alu_c;
            end
            if (bus.zf_en && exec_phase) begin
                z_q <= bus.alu_z;
            end
        end
    end

    // Decode straight from IR; every path assigns exactly one bit so the output stays one-hot
    always_comb begin
        dec = '0;
        case (ir_q[7:4])
            4'b0000: dec.nop  = 1'b1;
            4'b0001: dec.halt = 1'b1;
            4'b0010: dec.in1  = 1'b1;
            4'b0011: begin
                case (ir_q[1:0])
                    2'b00:   dec.jmp = 1'b1;
                    2'b01:   dec.jz  = 1'b1;
                    2'b10:   dec.jc  = 1'b1;
                    default: dec.nop = 1'b1;
                endcase
            end
            4'b0100: dec.out1 = 1'b1;
            4'b0101: dec.not1 = 1'b1;
            4'b0110: dec.sub  = 1'b1;
            4'b1001: dec.add  = 1'b1;
            4'b1010: dec.rsr  = 1'b1;
            4'b1011: dec.and1 = 1'b1;
            4'b1100: dec.rsl  = 1'b1;
            4'b1111: begin
                // movb wins over movc when both fields are 11
                if (ir_q[3:2] == 2'b11) begin
                    dec.movb = 1'b1;
                end else if (ir_q[1:0] == 2'b11) begin
                    dec.movc = 1'b1;
                end else begin
                    dec.mova = 1'b1;
                end
            end
            default: dec.nop  = 1'b1;
        endcase
    end

    assign bus.ir   = ir_q;
    assign bus.sm   = exec_phase;
    assign bus.c    = c_q;
    assign bus.z    = z_q;
    assign bus.icnt = icnt_q;

    assign bus.mova = dec.mova;
    assign bus.movb = dec.movb;
    assign bus.movc = dec.movc;
    assign bus.add  = dec.add;
    assign bus.sub  = dec.sub;
    assign bus.and1 = dec.and1;
    assign bus.not1 = dec.not1;
    assign bus.rsr  = dec.rsr;
    assign bus.rsl  = dec.rsl;
    assign bus.jmp  = dec.jmp;
    assign bus.jz   = dec.jz;
    assign bus.jc   = dec.jc;
    assign bus.in1  = dec.in1;
    assign bus.out1 = dec.out1;
    assign bus.nop  = dec.nop;
    assign bus.halt = dec.halt;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: vector table plus halt, wrap and decode-sweep sequences.
module tb_instr_seq;

    localparam logic [15:0] D_MOVA = 16'h8000;
    localparam logic [15:0] D_MOVB = 16'h4000;
    localparam logic [15:0] D_MOVC = 16'h2000;
    localparam logic [15:0] D_ADD  = 16'h1000;
    localparam logic [15:0] D_SUB  = 16'h0800;
    localparam logic [15:0] D_AND1 = 16'h0400;
    localparam logic [15:0] D_NOT1 = 16'h0200;
    localparam logic [15:0] D_RSR  = 16'h0100;
    localparam logic [15:0] D_RSL  = 16'h0080;
    localparam logic [15:0] D_JMP  = 16'h0040;
    localparam logic [15:0] D_JZ   = 16'h0020;
    localparam logic [15:0] D_JC   = 16'h0010;
    localparam logic [15:0] D_IN1  = 16'h0008;
    localparam logic [15:0] D_OUT1 = 16'h0004;
    localparam logic [15:0] D_NOP  = 16'h0002;
    localparam logic [15:0] D_HALT = 16'h0001;

    typedef struct {
        logic        rst;
        logic [7:0]  dbus;
        logic        ir_ld;
        logic        sm_en;
        logic        cf_en;
        logic        zf_en;
        logic        alu_c;
        logic        alu_z;
        logic [7:0]  e_ir;
        logic        e_sm;
        logic        e_c;
        logic        e_z;
        logic [7:0]  e_icnt;
        logic [15:0] e_dec;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    vec_t vq[$];

    instr_seq_if sif ();

    instr_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic r, logic [7:0] d, logic ld, logic se, logic ce, logic ze,
                                logic ac, logic az, logic [7:0] eir, logic esm, logic ec,
                                logic ez, logic [7:0] eic, logic [15:0] edec);
        vec_t v;
        v.rst = r; v.dbus = d; v.ir_ld = ld; v.sm_en = se; v.cf_en = ce; v.zf_en = ze;
        v.alu_c = ac; v.alu_z = az; v.e_ir = eir; v.e_sm = esm; v.e_c = ec; v.e_z = ez;
        v.e_icnt = eic; v.e_dec = edec;
        return v;
    endfunction

    // Reference decode written from the opcode table, independent of the RTL case structure
    function automatic logic [15:0] ref_dec(logic [7:0] b);
        logic [3:0] op;
        op = b[7:4];
        if (op == 4'h1) return D_HALT;
        if (op == 4'h2) return D_IN1;
        if (op == 4'h4) return D_OUT1;
        if (op == 4'h5) return D_NOT1;
        if (op == 4'h6) return D_SUB;
        if (op == 4'h9) return D_ADD;
        if (op == 4'hA) return D_RSR;
        if (op == 4'hB) return D_AND1;
        if (op == 4'hC) return D_RSL;
        if (op == 4'h3) begin
            if (b[1:0] == 2'd0) return D_JMP;
            if (b[1:0] == 2'd1) return D_JZ;
            if (b[1:0] == 2'd2) return D_JC;
            return D_NOP;
        end
        if (op == 4'hF) begin
            if (b[3] && b[2]) return D_MOVB;
            if (b[1] && b[0]) return D_MOVC;
            return D_MOVA;
        end
        return D_NOP;
    endfunction

    function automatic logic [15:0] act_dec();
        return {sif.mova, sif.movb, sif.movc, sif.add, sif.sub, sif.and1, sif.not1, sif.rsr,
                sif.rsl, sif.jmp, sif.jz, sif.jc, sif.in1, sif.out1, sif.nop, sif.halt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic ld, input logic se,
                         input logic ce, input logic ze, input logic ac, input logic az);
        rst = r; sif.dbus = d; sif.ir_ld = ld; sif.sm_en = se;
        sif.cf_en = ce; sif.zf_en = ze; sif.alu_c = ac; sif.alu_z = az;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //           rst dbus  ld se ce ze ac az   ir   sm c  z  icnt  decode
        vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, D_NOP));
        vq.push_back(mk(0, 8'h94, 1, 1, 0, 0, 0, 0, 8'h94, 1, 0, 0, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h94, 1, 1, 0, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h94, 0, 1, 0, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 8'h94, 0, 1, 0, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h94, 1, 1, 0, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h94, 1, 1, 1, 8'h01, D_ADD));
        vq.push_back(mk(0, 8'hFF, 1, 1, 0, 0, 0, 0, 8'hFF, 0, 1, 1, 8'h02, D_MOVB));
        vq.push_back(mk(0, 8'hF3, 1, 0, 0, 0, 0, 0, 8'hF3, 0, 1, 1, 8'h03, D_MOVC));
        vq.push_back(mk(0, 8'hF4, 1, 0, 0, 0, 0, 0, 8'hF4, 0, 1, 1, 8'h04, D_MOVA));
        vq.push_back(mk(0, 8'h30, 1, 0, 0, 0, 0, 0, 8'h30, 0, 1, 1, 8'h05, D_JMP));
        vq.push_back(mk(0, 8'h31, 1, 0, 0, 0, 0, 0, 8'h31, 0, 1, 1, 8'h06, D_JZ));
        vq.push_back(mk(0, 8'h32, 1, 0, 0, 0, 0, 0, 8'h32, 0, 1, 1, 8'h07, D_JC));
        vq.push_back(mk(0, 8'h33, 1, 0, 0, 0, 0, 0, 8'h33, 0, 1, 1, 8'h08, D_NOP));
        vq.push_back(mk(0, 8'h70, 1, 0, 0, 0, 0, 0, 8'h70, 0, 1, 1, 8'h09, D_NOP));
        vq.push_back(mk(0, 8'h25, 1, 0, 0, 0, 0, 0, 8'h25, 0, 1, 1, 8'h0A, D_IN1));
        vq.push_back(mk(0, 8'h4A, 1, 0, 0, 0, 0, 0, 8'h4A, 0, 1, 1, 8'h0B, D_OUT1));
        vq.push_back(mk(0, 8'h5C, 1, 0, 0, 0, 0, 0, 8'h5C, 0, 1, 1, 8'h0C, D_NOT1));
        vq.push_back(mk(0, 8'h61, 1, 0, 0, 0, 0, 0, 8'h61, 0, 1, 1, 8'h0D, D_SUB));
        vq.push_back(mk(0, 8'hA2, 1, 0, 0, 0, 0, 0, 8'hA2, 0, 1, 1, 8'h0E, D_RSR));
        vq.push_back(mk(0, 8'hB3, 1, 0, 0, 0, 0, 0, 8'hB3, 0, 1, 1, 8'h0F, D_AND1));
        vq.push_back(mk(0, 8'hC4, 1, 0, 0, 0, 0, 0, 8'hC4, 0, 1, 1, 8'h10, D_RSL));
        vq.push_back(mk(0, 8'h80, 1, 0, 0, 0, 0, 0, 8'h80, 0, 1, 1, 8'h11, D_NOP));
        vq.push_back(mk(0, 8'hD5, 1, 0, 0, 0, 0, 0, 8'hD5, 0, 1, 1, 8'h12, D_NOP));
        vq.push_back(mk(0, 8'hE6, 1, 0, 0, 0, 0, 0, 8'hE6, 0, 1, 1, 8'h13, D_NOP));
        vq.push_back(mk(0, 8'hF8, 1, 0, 0, 0, 0, 0, 8'hF8, 0, 1, 1, 8'h14, D_MOVA));
        vq.push_back(mk(0, 8'hFC, 1, 0, 0, 0, 0, 0, 8'hFC, 0, 1, 1, 8'h15, D_MOVB));
        vq.push_back(mk(0, 8'hF7, 1, 0, 0, 0, 0, 0, 8'hF7, 0, 1, 1, 8'h16, D_MOVC));
        vq.push_back(mk(0, 8'h1F, 1, 0, 0, 0, 0, 0, 8'h1F, 0, 1, 1, 8'h17, D_HALT));
        vq.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h1F, 0, 1, 1, 8'h17, D_HALT));
        vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h1F, 1, 1, 1, 8'h17, D_HALT));
        vq.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h1F, 1, 0, 1, 8'h17, D_HALT));
        vq.push_back(mk(1, 8'hAA, 1, 1, 1, 1, 1, 1, 8'h00, 0, 0, 0, 8'h00, D_NOP));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].dbus, vq[i].ir_ld, vq[i].sm_en,
                  vq[i].cf_en, vq[i].zf_en, vq[i].alu_c, vq[i].alu_z);
            step();
            check($sformatf("vec%0d {ir,sm,c,z,icnt,dec}", i),
                  64'({sif.ir, sif.sm, sif.c, sif.z, sif.icnt, act_dec()}),
                  64'({vq[i].e_ir, vq[i].e_sm, vq[i].e_c, vq[i].e_z, vq[i].e_icnt, vq[i].e_dec}));
        end

        // Halt: fetch 0x10, then downstream holds sm_en = ~halt for 10 cycles
        drive(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("halt_fetch {ir,sm,icnt,dec}",
              64'({sif.ir, sif.sm, sif.icnt, act_dec()}), 64'({8'h10, 1'b1, 8'h01, D_HALT}));
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 8'h5A, 1'b0, ~sif.halt, 1'b0, 1'b0, k[0], ~k[0]);
            step();
            check($sformatf("halt_hold%0d {ir,sm,c,z,icnt}", k),
                  64'({sif.ir, sif.sm, sif.c, sif.z, sif.icnt}),
                  64'({8'h10, 1'b1, 1'b0, 1'b0, 8'h01}));
        end
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("halt_reset {ir,sm,icnt,dec}",
              64'({sif.ir, sif.sm, sif.icnt, act_dec()}), 64'({8'h00, 1'b0, 8'h00, D_NOP}));

        // 256 fetches sweep every IR value and wrap the counter back to zero
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b;
            b = 8'(v);
            drive(1'b0, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            check($sformatf("sweep%02h {ir,onehot,dec}", b),
                  64'({sif.ir, ($countones(act_dec()) == 1), act_dec()}),
                  64'({b, 1'b1, ref_dec(b)}));
            if (v == 254) begin
                check("icnt_at_255", 64'(sif.icnt), 64'(8'hFF));
            end
        end
        check("icnt_wrap", 64'(sif.icnt), 64'(8'h00));

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("idle_hold {ir,icnt}", 64'({sif.ir, sif.icnt}), 64'({8'hFF, 8'h00}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
